// File: rtl/vol_ramp_ctrl_pkg.sv
// Shared types and defaults for the volume ramp controller.
// The VOL_AUTOREPEAT_EN macro is consumed by vol_ramp_ctrl.sv, not here.
package vol_pkg;

  function automatic int unsigned lvl_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic [15:0] DEF_STEP_SIZE = 16'h0800;
  localparam logic [15:0] DEF_RAMP_INC  = 16'h0100;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_HOLD,
    BTN_REPEAT
  } btn_state_e;

endpackage

// File: rtl/vol_ramp_ctrl_if.sv
// Button inputs and volume outputs of vol_ramp_ctrl, bundled for the board/mixer side.
interface vol_ramp_ctrl_if #(
  parameter int unsigned NUM_STEPS = 10,
  parameter int unsigned GAIN_W    = 16
);
  localparam int unsigned LVL_W = vol_pkg::lvl_w(NUM_STEPS);

  logic              tick;
  logic              up;
  logic              down;
  logic              mute;
  logic [LVL_W-1:0]  level;
  logic [GAIN_W-1:0] gain;
  logic              muted;
  logic              ramping;

  modport master (output tick, up, down, mute, input level, gain, muted, ramping);
  modport slave  (input tick, up, down, mute, output level, gain, muted, ramping);
endinterface

// File: rtl/vol_btn_repeat.sv
// Rising-edge event generator for one button, with an optional hold-to-repeat FSM
// (REPEAT_EN=1): first repeat after REPEAT_DLY ticks, then every REPEAT_PER ticks.
module vol_btn_repeat
  import vol_pkg::*;
#(
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_DLY = 50,
  parameter int unsigned REPEAT_PER = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic evt
);
  logic btn_q;
  logic edge_evt;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign edge_evt = btn & ~btn_q;

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

      btn_state_e       state, state_n;
      logic [CNT_W-1:0] cnt, cnt_n;
      logic             rep_evt;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= BTN_IDLE;
          cnt   <= '0;
        end else begin
          state <= state_n;
          cnt   <= cnt_n;
        end
      end

      always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rep_evt = 1'b0;
        if (!btn) begin
          state_n = BTN_IDLE;
          cnt_n   = '0;
        end else begin
          case (state)
            BTN_IDLE: if (edge_evt) begin
              state_n = BTN_HOLD;
              cnt_n   = '0;
            end
            BTN_HOLD: if (tick) begin
              if (cnt == CNT_W'(REPEAT_DLY - 1)) begin
                rep_evt = 1'b1;
                state_n = BTN_REPEAT;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt + 1'b1;
              end
            end
            BTN_REPEAT: if (tick) begin
              if (cnt == CNT_W'(REPEAT_PER - 1)) begin
                rep_evt = 1'b1;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt + 1'b1;
              end
            end
            default: state_n = BTN_IDLE;
          endcase
        end
      end

      assign evt = edge_evt | rep_evt;
    end else begin : g_edge
      logic unused_tick;
      assign unused_tick = tick;
      assign evt         = edge_evt;
    end
  endgenerate

endmodule

// File: rtl/vol_ramp_ctrl.sv
// Volume level/mute registers with a tick-paced, click-free gain ramp.
// Define VOL_AUTOREPEAT_EN to enable hold-to-repeat on the up/down buttons.
module vol_ramp_ctrl
  import vol_pkg::*;
#(
  parameter int unsigned       NUM_STEPS  = 10,
  parameter int unsigned       GAIN_W     = 16,
  parameter logic [GAIN_W-1:0] STEP_SIZE  = DEF_STEP_SIZE,
  parameter int unsigned       RESET_LVL  = 1,
  parameter logic [GAIN_W-1:0] RAMP_INC   = DEF_RAMP_INC,
  parameter int unsigned       REPEAT_DLY = 50,
  parameter int unsigned       REPEAT_PER = 10
) (
  input logic          clk,
  input logic          rst,
  vol_ramp_ctrl_if.slave bus
);
  localparam int unsigned      LVL_W   = lvl_w(NUM_STEPS);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_STEPS - 1);
`ifdef VOL_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic              up_evt, down_evt, mute_evt, step_evt;
  logic [LVL_W-1:0]  level;
  logic              muted;
  logic [GAIN_W-1:0] gain, gain_n, target;

  vol_btn_repeat #(.REPEAT_EN(AUTOREP), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_up   (.clk(clk), .rst(rst), .tick(bus.tick), .btn(bus.up),   .evt(up_evt));
  vol_btn_repeat #(.REPEAT_EN(AUTOREP), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_down (.clk(clk), .rst(rst), .tick(bus.tick), .btn(bus.down), .evt(down_evt));
  vol_btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
    u_mute (.clk(clk), .rst(rst), .tick(bus.tick), .btn(bus.mute), .evt(mute_evt));

  // Simultaneous up and down cancel; a lone step also unmutes.
  assign step_evt = up_evt ^ down_evt;
  assign target   = muted ? '0 : GAIN_W'(level) * STEP_SIZE;

  always_comb begin
    gain_n = gain;
    if (bus.tick) begin
      if (gain < target)
        gain_n = ((target - gain) > RAMP_INC) ? gain + RAMP_INC : target;
      else if (gain > target)
        gain_n = ((gain - target) > RAMP_INC) ? gain - RAMP_INC : target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= LVL_W'(RESET_LVL);
      muted <= 1'b0;
      gain  <= GAIN_W'(RESET_LVL) * STEP_SIZE;
    end else begin
      gain <= gain_n;
      if (step_evt && muted) muted <= 1'b0;
      else if (mute_evt)     muted <= ~muted;
      if (step_evt) begin
        if (up_evt && level != LVL_MAX)   level <= level + 1'b1;
        if (down_evt && level != '0)      level <= level - 1'b1;
      end
    end
  end

  assign bus.level   = level;
  assign bus.gain    = gain;
  assign bus.muted   = muted;
  assign bus.ramping = (gain != target);

endmodule

// File: tb/tb_vol_ramp_ctrl.sv
// Self-checking bench for vol_ramp_ctrl: directed scenarios plus random button/tick traffic,
// all compared every cycle against an arithmetic model of level, mute and gain.
module tb_vol_ramp_ctrl;
  localparam int STEP = 'h0800;
  localparam int INC  = 'h0100;
  localparam int DLY  = 50;
  localparam int PER  = 10;
  localparam int NMAX = 9;
`ifdef VOL_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vol_ramp_ctrl_if #(.NUM_STEPS(10), .GAIN_W(16)) bus ();

  vol_ramp_ctrl #(
    .NUM_STEPS(10), .GAIN_W(16), .STEP_SIZE(16'h0800), .RESET_LVL(1),
    .RAMP_INC(16'h0100), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: evaluated on each clock edge from the sampled inputs.
  int m_level = 1, m_muted = 0, m_gain = STEP;
  int held [2];
  bit prevb [2];
  bit prev_m;
  bit btnv [2];
  bit ev [2];
  bit me;
  int tgt;

  function automatic int m_target();
    return m_muted ? 0 : m_level * STEP;
  endfunction

  always @(posedge clk) begin
    btnv[0] = bus.up;
    btnv[1] = bus.down;
    if (rst) begin
      m_level = 1; m_muted = 0; m_gain = STEP;
      held = '{0, 0}; prevb = '{0, 0}; prev_m = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        ev[b] = 0;
        if (!btnv[b]) held[b] = 0;
        else if (!prevb[b]) begin
          ev[b] = 1;
          held[b] = 0;
        end else if (AUTOREP && bus.tick) begin
          held[b]++;
          if (held[b] == DLY || (held[b] > DLY && (held[b] - DLY) % PER == 0)) ev[b] = 1;
        end
        prevb[b] = btnv[b];
      end
      me = bus.mute && !prev_m;
      prev_m = bus.mute;
      tgt = m_target();
      if (bus.tick) begin
        if (m_gain < tgt)      m_gain = (m_gain + INC < tgt) ? m_gain + INC : tgt;
        else if (m_gain > tgt) m_gain = (m_gain - INC > tgt) ? m_gain - INC : tgt;
      end
      if (ev[0] != ev[1] && m_muted != 0) m_muted = 0;
      else if (me)                        m_muted = m_muted ? 0 : 1;
      if (ev[0] && !ev[1]) m_level = (m_level < NMAX) ? m_level + 1 : NMAX;
      if (ev[1] && !ev[0]) m_level = (m_level > 0) ? m_level - 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level",   int'(bus.level),   m_level);
      chk("gain",    int'(bus.gain),    m_gain);
      chk("muted",   int'(bus.muted),   m_muted);
      chk("ramping", int'(bus.ramping), (m_gain != m_target()) ? 1 : 0);
    end
  end

  bit b_up, b_down, b_mute;

  task automatic cycle(input bit t);
    @(negedge clk);
    bus.tick = t;
    bus.up   = b_up;
    bus.down = b_down;
    bus.mute = b_mute;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b0);
    end
  endtask

  task automatic press(input bit u, input bit d, input bit m);
    b_up = u; b_down = d; b_mute = m;
    cycle(1'b0);
    b_up = 0; b_down = 0; b_mute = 0;
    cycle(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    cycle(1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 0; bus.up = 0; bus.down = 0; bus.mute = 0;
    b_up = 0; b_down = 0; b_mute = 0;
    cycle(1'b0);
    do_reset();
    chk_en = 1'b1;
    chk("rst_level", int'(bus.level), 1);
    chk("rst_gain", int'(bus.gain), 'h0800);
    chk("rst_muted", int'(bus.muted), 0);
    chk("rst_ramping", int'(bus.ramping), 0);

    repeat (12) press(1, 0, 0);
    chk("sat_up_level", int'(bus.level), 9);
    ticks(70);
    chk("sat_up_gain", int'(bus.gain), 'h4800);
    repeat (12) press(0, 1, 0);
    chk("sat_dn_level", int'(bus.level), 0);
    ticks(80);
    chk("sat_dn_gain", int'(bus.gain), 0);

    do_reset();
    repeat (4) press(1, 0, 0);
    chk("ramp_level", int'(bus.level), 5);
    ticks(31);
    chk("ramp_gain31", int'(bus.gain), 'h2700);
    chk("ramp_busy31", int'(bus.ramping), 1);
    ticks(1);
    chk("ramp_gain32", int'(bus.gain), 'h2800);
    chk("ramp_done32", int'(bus.ramping), 0);
    ticks(5);
    chk("ramp_hold", int'(bus.gain), 'h2800);

    press(0, 1, 0);
    ticks(20);
    press(0, 0, 1);
    chk("mute_on", int'(bus.muted), 1);
    chk("mute_level", int'(bus.level), 4);
    ticks(40);
    chk("mute_gain", int'(bus.gain), 0);
    press(1, 0, 0);
    chk("unmute_muted", int'(bus.muted), 0);
    chk("unmute_level", int'(bus.level), 5);
    chk("unmute_ramping", int'(bus.ramping), 1);
    ticks(50);
    chk("unmute_gain", int'(bus.gain), 'h2800);

    press(1, 1, 0);
    chk("updn_level", int'(bus.level), 5);
    chk("updn_muted", int'(bus.muted), 0);
    press(1, 1, 1);
    chk("updnm_level", int'(bus.level), 5);
    chk("updnm_muted", int'(bus.muted), 1);
    press(0, 0, 1);
    chk("remute_muted", int'(bus.muted), 0);

    do_reset();
    press(0, 1, 0);
    b_up = 1;
    cycle(1'b0);
    ticks(49);
    chk("hold49", int'(bus.level), 1);
    ticks(1);
    chk("hold50", int'(bus.level), AUTOREP ? 2 : 1);
    ticks(70);
    chk("hold120", int'(bus.level), AUTOREP ? 9 : 1);
    ticks(20);
    rst = 1'b1;
    b_up = 0;
    cycle(1'b0);
    rst = 1'b0;
    cycle(1'b0);
    chk("hold_rst_level", int'(bus.level), 1);
    ticks(80);
    chk("hold_rst_after", int'(bus.level), 1);
    chk("hold_rst_gain", int'(bus.gain), 'h0800);

    // Random traffic: presses are short-lived to start but some holds run long enough to repeat.
    for (int i = 0; i < 4000; i++) begin
      if (b_up) b_up = ($urandom_range(0, 199) != 0); else b_up = ($urandom_range(0, 29) == 0);
      if (b_down) b_down = ($urandom_range(0, 59) != 0); else b_down = ($urandom_range(0, 29) == 0);
      b_mute = b_mute ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 799) == 0);
      cycle($urandom_range(0, 2) == 0);
    end
    rst = 1'b0;
    b_up = 0; b_down = 0; b_mute = 0;
    cycle(1'b0);
    cycle(1'b0);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
